// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared constants for the PS/2 scancode receiver
package ps2_pkg;

    // Prefix bytes folded into flags instead of being reported as keys
    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    // Frame receiver states
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

endpackage

// File: rtl/ps2_sync_filter.sv
// rtl/ps2_sync_filter.sv - 2-FF synchroniser plus consecutive-sample deglitch filter
module ps2_sync_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

    logic          meta_q;
    logic          sync_q;
    logic          dout_q;
    logic [CW-1:0] cnt_q;

    // Two-stage synchroniser; idles high like an undriven PS/2 line
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
        end
    end

    // Output follows the input only after FILTER_LEN consecutive differing samples
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout_q <= 1'b1;
            cnt_q  <= '0;
        end else if (sync_q == dout_q) begin
            cnt_q  <= '0;
        end else if (cnt_q == CNT_LAST) begin
            dout_q <= sync_q;
            cnt_q  <= '0;
        end else begin
            cnt_q  <= cnt_q + 1'b1;
        end
    end

    assign dout = dout_q;

endmodule

// File: rtl/ps2_scancode_rx.sv
// rtl/ps2_scancode_rx.sv - PS/2 frame receiver and scancode decoder; optional REPEAT_SUPPRESS_EN
module ps2_scancode_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2clk,
    input  logic       ps2data,
    output logic [7:0] keyval,
    output logic       key_valid,
    output logic       key_break,
    output logic       key_ext,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic          filt_clk;
    logic          filt_data;
    logic          filt_clk_q;
    logic          fall;

    logic [1:0]    state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_d;
    logic          good_d, good_q;

    logic          brk_flag_q, brk_flag_d;
    logic          ext_flag_q, ext_flag_d;
    logic          strobe_d;

    logic [7:0]    keyval_q;
    logic          key_valid_q;
    logic          key_break_q;
    logic          key_ext_q;
    logic          frame_err_q;

    ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (ps2clk),
        .dout  (filt_clk)
    );

    ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (ps2data),
        .dout  (filt_data)
    );

    // Delayed filtered clock for falling-edge detection
    always_ff @(posedge clk) begin
        if (!rst_n) filt_clk_q <= 1'b1;
        else        filt_clk_q <= filt_clk;
    end

    assign fall = filt_clk_q & ~filt_clk;

    // Frame FSM: start, 8 data bits LSB first, odd parity, stop; plus inter-edge timeout
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        err_d     = 1'b0;
        good_d    = 1'b0;
        if (state_q == ST_IDLE || fall) tmo_d = '0;
        else                            tmo_d = tmo_q + 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (fall) begin
                    if (!filt_data) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = 3'd0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (fall) begin
                    shift_d = {filt_data, shift_q[7:1]};
                    if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
                    else                   bit_cnt_d = bit_cnt_q + 3'd1;
                end
            end
            ST_PARITY: begin
                if (fall) begin
                    par_d   = filt_data;
                    state_d = ST_STOP;
                end
            end
            default: begin
                if (fall) begin
                    if (filt_data && ((^shift_q) ^ par_q)) good_d = 1'b1;
                    else                                   err_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
        endcase

        // A fall in the same cycle restarts the window, so it takes priority
        if (state_q != ST_IDLE && !fall && tmo_q == TMO_LAST) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
        end
    end

    // Frame FSM state registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'h00;
            par_q     <= 1'b0;
            tmo_q     <= '0;
            good_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            tmo_q     <= tmo_d;
            good_q    <= good_d;
        end
    end

`ifdef REPEAT_SUPPRESS_EN
    logic       held_v_q, held_v_d;
    logic [8:0] held_q, held_d;
`endif

    // Decode a good frame one cycle after its stop bit; shift_q is stable until the next frame's data
    always_comb begin
        brk_flag_d = brk_flag_q;
        ext_flag_d = ext_flag_q;
        strobe_d   = 1'b0;
`ifdef REPEAT_SUPPRESS_EN
        held_v_d   = held_v_q;
        held_d     = held_q;
`endif
        if (err_d) begin
            brk_flag_d = 1'b0;
            ext_flag_d = 1'b0;
        end else if (good_q) begin
            if (shift_q == PS2_EXT) begin
                ext_flag_d = 1'b1;
            end else if (shift_q == PS2_BRK) begin
                brk_flag_d = 1'b1;
            end else begin
                brk_flag_d = 1'b0;
                ext_flag_d = 1'b0;
                strobe_d   = 1'b1;
`ifdef REPEAT_SUPPRESS_EN
                // Typematic repeats of the held key are dropped; its release frees the slot
                if (held_v_q && held_q == {ext_flag_q, shift_q}) begin
                    if (brk_flag_q) held_v_d = 1'b0;
                    else            strobe_d = 1'b0;
                end else if (!brk_flag_q) begin
                    held_v_d = 1'b1;
                    held_d   = {ext_flag_q, shift_q};
                end
`endif
            end
        end
    end

    // Prefix flags and registered key outputs; key fields hold between strobes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            brk_flag_q  <= 1'b0;
            ext_flag_q  <= 1'b0;
            keyval_q    <= 8'h00;
            key_valid_q <= 1'b0;
            key_break_q <= 1'b0;
            key_ext_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            brk_flag_q  <= brk_flag_d;
            ext_flag_q  <= ext_flag_d;
            key_valid_q <= strobe_d;
            frame_err_q <= err_d;
            if (strobe_d) begin
                keyval_q    <= shift_q;
                key_break_q <= brk_flag_q;
                key_ext_q   <= ext_flag_q;
            end
        end
    end

`ifdef REPEAT_SUPPRESS_EN
    // Last make not yet released
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            held_v_q <= 1'b0;
            held_q   <= 9'h000;
        end else begin
            held_v_q <= held_v_d;
            held_q   <= held_d;
        end
    end
`endif

    assign keyval    = keyval_q;
    assign key_valid = key_valid_q;
    assign key_break = key_break_q;
    assign key_ext   = key_ext_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// tb/tb_ps2_scancode_rx.sv - scoreboard bench for ps2_scancode_rx; model follows REPEAT_SUPPRESS_EN
module tb_ps2_scancode_rx;

    localparam int FILTER_LEN     = 8;
    localparam int TIMEOUT_CYCLES = 600;
    localparam int HALF           = 40;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2clk = 1'b1;
    logic       ps2data = 1'b1;
    logic [7:0] keyval;
    logic       key_valid;
    logic       key_break;
    logic       key_ext;
    logic       frame_err;

    ps2_scancode_rx #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ps2clk    (ps2clk),
        .ps2data   (ps2data),
        .keyval    (keyval),
        .key_valid (key_valid),
        .key_break (key_break),
        .key_ext   (key_ext),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] code;
        logic       brk;
        logic       ext;
    } ev_t;

    ev_t    exp_q[$];
    int     exp_err = 0;
    int     n_checks = 0;
    int     n_fail = 0;
    int     err_seen = 0;
    int     key_seen = 0;
    longint t_fall = 0;
    longint t_err = 0;

    bit         m_brk = 0;
    bit         m_ext = 0;
    bit         m_held_v = 0;
    logic [8:0] m_held = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_brk = 0;
        m_ext = 0;
        m_held_v = 0;
        exp_q.delete();
        exp_err = 0;
    endtask

    task automatic model_err();
        m_brk = 0;
        m_ext = 0;
        exp_err++;
    endtask

    task automatic model_byte(input logic [7:0] b);
        bit emit;
        if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else begin
            emit = 1;
`ifdef REPEAT_SUPPRESS_EN
            if (m_brk) begin
                if (m_held_v && m_held == {m_ext, b}) m_held_v = 0;
            end else if (m_held_v && m_held == {m_ext, b}) begin
                emit = 0;
            end else begin
                m_held_v = 1;
                m_held = {m_ext, b};
            end
`endif
            if (emit) exp_q.push_back('{code: b, brk: m_brk, ext: m_ext});
            m_brk = 0;
            m_ext = 0;
        end
    endtask

    // Monitor: pops expectations whenever the DUT strobes
    always @(negedge clk) begin
        if (rst_n) begin
            if (key_valid && frame_err) begin
                n_checks++;
                n_fail++;
                $display("FAIL valid_err_overlap: key_valid and frame_err both 1");
            end
            if (key_valid) begin
                ev_t ev;
                key_seen++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_key: keyval 0x%0h brk %0b ext %0b, none expected", keyval, key_break, key_ext);
                end else begin
                    ev = exp_q.pop_front();
                    check("keyval", {24'h0, keyval}, {24'h0, ev.code});
                    check("key_break", {31'h0, key_break}, {31'h0, ev.brk});
                    check("key_ext", {31'h0, key_ext}, {31'h0, ev.ext});
                end
            end
            if (frame_err) begin
                err_seen++;
                t_err = $time;
                n_checks++;
                if (exp_err == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_frame_err: frame_err 1, expected 0");
                end else begin
                    exp_err--;
                end
            end
        end
    end

    task automatic clk_wait(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input bit b);
        ps2data = b;
        clk_wait(HALF / 2);
        ps2clk = 1'b0;
        t_fall = $time;
        clk_wait(HALF);
        ps2clk = 1'b1;
        clk_wait(HALF / 2);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par);
        bit p;
        if (bad_par) model_err();
        else         model_byte(b);
        p = (~^b) ^ bad_par;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(p);
        send_bit(1'b1);
        clk_wait(60);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_keyval"}, {24'h0, keyval}, 32'h0);
        check({tag, "_key_valid"}, {31'h0, key_valid}, 32'h0);
        check({tag, "_key_break"}, {31'h0, key_break}, 32'h0);
        check({tag, "_key_ext"}, {31'h0, key_ext}, 32'h0);
        check({tag, "_frame_err"}, {31'h0, frame_err}, 32'h0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g0, k0;
        logic [7:0] b;
        bit bad;

        clk_wait(4);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        clk_wait(20);

        // Directed sequences
        send_frame(8'h1C, 0);
        send_frame(8'hF0, 0);
        send_frame(8'h1C, 0);
        send_frame(8'hE0, 0);
        send_frame(8'hF0, 0);
        send_frame(8'h75, 0);
        send_frame(8'h6B, 0);
        send_frame(8'h75, 1);
        send_frame(8'h74, 0);

        // Truncated frame: start plus 5 data bits, then ps2clk parked high
        model_err();
        t_err = 0;
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)));
        for (int i = 0; i < TIMEOUT_CYCLES + 200 && exp_err != 0; i++) clk_wait(1);
        check("timeout_fired", exp_err, 0);
        check("timeout_latency", 32'((t_err - t_fall) / 10), TIMEOUT_CYCLES + FILTER_LEN + 3);
        exp_err = 0;
        send_frame(8'h29, 0);

        // Short glitch on ps2clk while idle
        g0 = err_seen;
        k0 = key_seen;
        ps2clk = 1'b0;
        clk_wait(3);
        ps2clk = 1'b1;
        clk_wait(40);
        check("glitch_no_err", err_seen - g0, 0);
        check("glitch_no_key", key_seen - k0, 0);
        send_frame(8'h5A, 0);

        // Make, repeat, break of the same key
        send_frame(8'h1C, 0);
        send_frame(8'h1C, 0);
        send_frame(8'hF0, 0);
        send_frame(8'h1C, 0);

        // Reset in the middle of a frame
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        ps2data = 1'b1;
        rst_n = 1'b0;
        clk_wait(3);
        check_reset_outputs("midreset");
        model_reset();
        rst_n = 1'b1;
        clk_wait(50);
        send_frame(8'h23, 0);

        // Randomized traffic including prefixes and parity errors
        for (int n = 0; n < 24; n++) begin
            case ($urandom_range(0, 9))
                0:       b = 8'hE0;
                1:       b = 8'hF0;
                2:       b = 8'h1C;
                default: b = 8'($urandom);
            endcase
            bad = ($urandom_range(0, 7) == 0);
            send_frame(b, bad);
        end

        clk_wait(200);
        check("pending_events", exp_q.size(), 0);
        check("pending_errors", exp_err, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
